// File: rtl/wb_demux.sv
// rtl/wb_demux.sv - registered 1-to-3 write-back result demultiplexer with a 2-entry FIFO
// Optional feature macro: WB_DEMUX_STATS_EN (adds cnt1..cnt3 delivered-word counters).
// Ports:
//   clk, reset                      single clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_sel producer stream; sel 00->1, 01->2, 10/11->3
//   outN_valid/outN_ready/outN_data  consumer ports 1..3; unselected ports show 0
//   cnt1/cnt2/cnt3                   per-port delivered-word counters (stats build only)
module wb_demux #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [1:0]        in_sel,
   output logic              out1_valid,
   input  logic              out1_ready,
   output logic [DATA_W-1:0] out1_data,
   output logic              out2_valid,
   input  logic              out2_ready,
   output logic [DATA_W-1:0] out2_data,
   output logic              out3_valid,
   input  logic              out3_ready,
   output logic [DATA_W-1:0] out3_data
`ifdef WB_DEMUX_STATS_EN
   ,
   output logic [15:0]       cnt1,
   output logic [15:0]       cnt2,
   output logic [15:0]       cnt3
`endif
);

   // Occupancy state doubles as the FIFO count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_t;

   occ_t              state;
   occ_t              state_nxt;
   logic [DATA_W-1:0] data_mem [2];
   logic [1:0]        sel_mem  [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic              push;
   logic              pop;
   logic [1:0]        head_sel;
   logic [DATA_W-1:0] head_data;

   assign head_sel  = sel_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];

   // Depends only on registered state and reset, so no ready pass-through path.
   assign in_ready = (state != FULL) && !reset;
   assign push     = in_valid && in_ready;

   // Only the selected port can show valid, so ready on other ports is ignored.
   assign pop = (out1_valid && out1_ready) ||
                (out2_valid && out2_ready) ||
                (out3_valid && out3_ready);

   always_comb begin
      out1_valid = 1'b0;
      out2_valid = 1'b0;
      out3_valid = 1'b0;
      out1_data  = '0;
      out2_data  = '0;
      out3_data  = '0;
      if (state != EMPTY) begin
         case (head_sel)
            2'b00: begin
               out1_valid = 1'b1;
               out1_data  = head_data;
            end
            2'b01: begin
               out2_valid = 1'b1;
               out2_data  = head_data;
            end
            default: begin
               out3_valid = 1'b1;
               out3_data  = head_data;
            end
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: if (push) state_nxt = ONE;
         ONE: begin
            if (push && !pop)      state_nxt = FULL;
            else if (pop && !push) state_nxt = EMPTY;
         end
         FULL:  if (pop) state_nxt = ONE;
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= EMPTY;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         state <= state_nxt;
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
      end
   end

   // Storage needs no reset: entries are only visible while the count covers them.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr] <= in_data;
         sel_mem[wr_ptr]  <= in_sel;
      end
   end

`ifdef WB_DEMUX_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt1 <= '0;
         cnt2 <= '0;
         cnt3 <= '0;
      end else begin
         if (out1_valid && out1_ready) cnt1 <= cnt1 + 16'd1;
         if (out2_valid && out2_ready) cnt2 <= cnt2 + 16'd1;
         if (out3_valid && out3_ready) cnt3 <= cnt3 + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_wb_demux.sv
// tb/tb_wb_demux.sv - scoreboard testbench for wb_demux
module tb_wb_demux;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [1:0] in_sel;
   logic       out1_valid, out2_valid, out3_valid;
   logic       out1_ready, out2_ready, out3_ready;
   logic [7:0] out1_data, out2_data, out3_data;
`ifdef WB_DEMUX_STATS_EN
   logic [15:0] cnt1, cnt2, cnt3;
`endif

   typedef struct {
      int         port;
      logic [7:0] data;
   } exp_t;

   exp_t        sb[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          deliv[4];
   logic [15:0] exp_cnt[4];
   logic        mon_en = 1'b0;

   always #5 clk = ~clk;

   wb_demux #(.DATA_W(8)) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .in_sel(in_sel),
      .out1_valid(out1_valid),
      .out1_ready(out1_ready),
      .out1_data(out1_data),
      .out2_valid(out2_valid),
      .out2_ready(out2_ready),
      .out2_data(out2_data),
      .out3_valid(out3_valid),
      .out3_ready(out3_ready),
      .out3_data(out3_data)
`ifdef WB_DEMUX_STATS_EN
      ,
      .cnt1(cnt1),
      .cnt2(cnt2),
      .cnt3(cnt3)
`endif
   );

   function automatic int port_of(input logic [1:0] sel);
      return (sel == 2'b00) ? 1 : (sel == 2'b01) ? 2 : 3;
   endfunction

   // Scoreboard consumer: every cycle the head of the expected queue must be
   // the only thing visible on the outputs; a handshake retires it.
   always @(negedge clk) begin
      if (mon_en) begin
         logic [2:0] exp_v;
         logic [7:0] exp_d1, exp_d2, exp_d3;
         exp_v  = 3'b000;
         exp_d1 = 8'h00;
         exp_d2 = 8'h00;
         exp_d3 = 8'h00;
         if (sb.size() != 0) begin
            case (sb[0].port)
               1: begin exp_v = 3'b001; exp_d1 = sb[0].data; end
               2: begin exp_v = 3'b010; exp_d2 = sb[0].data; end
               default: begin exp_v = 3'b100; exp_d3 = sb[0].data; end
            endcase
         end
         vectors++;
         if ({out3_valid, out2_valid, out1_valid} !== exp_v ||
             out1_data !== exp_d1 || out2_data !== exp_d2 || out3_data !== exp_d3) begin
            miscompares++;
            $display("FAIL head_route t=%0t got v=%b d=%h/%h/%h want v=%b d=%h/%h/%h", $time,
                     {out3_valid, out2_valid, out1_valid}, out1_data, out2_data, out3_data,
                     exp_v, exp_d1, exp_d2, exp_d3);
         end
         if (!reset && sb.size() != 0 &&
             ((out1_valid && out1_ready) || (out2_valid && out2_ready) || (out3_valid && out3_ready))) begin
            deliv[sb[0].port]++;
            exp_cnt[sb[0].port] = exp_cnt[sb[0].port] + 16'd1;
            void'(sb.pop_front());
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Offers one word until accepted (bounded); the expectation is queued once the edge passes.
   task automatic push(input logic [7:0] d, input logic [1:0] s, output int tries);
      logic acc;
      tries     = 0;
      acc       = 1'b0;
      in_valid  = 1'b1;
      in_data   = d;
      in_sel    = s;
      while (!acc && tries < 40) begin
         @(negedge clk);
         acc = in_ready;
         tries++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      vectors++;
      if (!acc) begin
         miscompares++;
         $display("FAIL push_timeout data=%h got in_ready=0 want 1 within 40 cycles", d);
      end else begin
         sb.push_back('{port: port_of(s), data: d});
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 600) begin
         cycle();
         n++;
      end
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain_timeout got %0d words left want 0", sb.size());
      end
   endtask

   task automatic check_counters(input string tag);
`ifdef WB_DEMUX_STATS_EN
      vectors++;
      if (cnt1 !== exp_cnt[1] || cnt2 !== exp_cnt[2] || cnt3 !== exp_cnt[3]) begin
         miscompares++;
         $display("FAIL %s_counters got %0d/%0d/%0d want %0d/%0d/%0d", tag,
                  cnt1, cnt2, cnt3, exp_cnt[1], exp_cnt[2], exp_cnt[3]);
      end
`else
      if (tag.len() == 0) $display("empty tag");
`endif
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in_valid = 1'b0; in_data = 8'h00; in_sel = 2'b00;
      out1_ready = 1'b1; out2_ready = 1'b1; out3_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin deliv[i] = 0; exp_cnt[i] = 16'd0; end
      cycle();
      cycle();
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_in_ready got %b want 0", in_ready);
      end
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL post_reset_in_ready got %b want 1", in_ready);
      end
      check_counters("reset");
      @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      int t;
      int d1 = deliv[1];
      push(8'hA5, 2'b00, t);
      drain();
      cycle();
      vectors++;
      if (deliv[1] - d1 !== 1) begin
         miscompares++;
         $display("FAIL single_deliv got %0d want 1", deliv[1] - d1);
      end
      check_counters("single");
   endtask

   task automatic test_full();
      int t;
      out1_ready = 1'b0; out2_ready = 1'b0; out3_ready = 1'b0;
      push(8'h11, 2'b10, t);
      push(8'h22, 2'b11, t);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (in_ready !== 1'b0 || out3_data !== 8'h11) begin
            miscompares++;
            $display("FAIL full_hold got in_ready=%b d3=%h want 0/11", in_ready, out3_data);
         end
         @(posedge clk);
         #1;
      end
      out3_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1 || out3_data !== 8'h22) begin
         miscompares++;
         $display("FAIL full_release got in_ready=%b d3=%h want 1/22", in_ready, out3_data);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (sb.size() !== 0) begin
         miscompares++;
         $display("FAIL full_consecutive got %0d left want 0", sb.size());
      end
      check_counters("full");
   endtask

   task automatic test_order();
      int t;
      int d1 = deliv[1];
      out1_ready = 1'b1; out2_ready = 1'b0; out3_ready = 1'b1;
      push(8'h33, 2'b01, t);
      push(8'h44, 2'b00, t);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         vectors++;
         if (out1_valid !== 1'b0 || out2_data !== 8'h33) begin
            miscompares++;
            $display("FAIL order_block got v1=%b d2=%h want 0/33", out1_valid, out2_data);
         end
         @(posedge clk);
         #1;
      end
      out2_ready = 1'b1;
      drain();
      vectors++;
      if (deliv[1] - d1 !== 1) begin
         miscompares++;
         $display("FAIL order_deliv got %0d want 1", deliv[1] - d1);
      end
      check_counters("order");
   endtask

   task automatic test_back_to_back();
      int t;
      int extra = 0;
      int b[4];
      out1_ready = 1'b1; out2_ready = 1'b1; out3_ready = 1'b1;
      for (int i = 1; i < 4; i++) b[i] = deliv[i];
      for (int i = 0; i < 256; i++) begin
         logic [7:0] d;
         d = 8'(i * 7 + 3);
         push(d, 2'(i), t);
         extra += t - 1;
      end
      drain();
      vectors++;
      if (extra !== 0) begin
         miscompares++;
         $display("FAIL stream_stalls got %0d want 0", extra);
      end
      vectors++;
      if (deliv[1] - b[1] !== 64 || deliv[2] - b[2] !== 64 || deliv[3] - b[3] !== 128) begin
         miscompares++;
         $display("FAIL stream_split got %0d/%0d/%0d want 64/64/128",
                  deliv[1] - b[1], deliv[2] - b[2], deliv[3] - b[3]);
      end
      check_counters("stream");
   endtask

   task automatic test_reset_mid();
      int t;
      int d1;
      out1_ready = 1'b0; out2_ready = 1'b0; out3_ready = 1'b0;
      push(8'h66, 2'b00, t);
      push(8'h77, 2'b01, t);
      reset = 1'b1;
      in_valid = 1'b1; in_data = 8'hEE; in_sel = 2'b00;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_ready got %b want 0", in_ready);
      end
      @(posedge clk);
      #1;
      sb.delete();
      for (int i = 1; i < 4; i++) exp_cnt[i] = 16'd0;
      reset = 1'b0;
      in_valid = 1'b0;
      out1_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if ({out3_valid, out2_valid, out1_valid} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_mid_flush got %b want 000", {out3_valid, out2_valid, out1_valid});
      end
      check_counters("reset_mid");
      @(posedge clk);
      #1;
      d1 = deliv[1];
      push(8'h5A, 2'b00, t);
      drain();
      cycle();
      vectors++;
      if (deliv[1] - d1 !== 1) begin
         miscompares++;
         $display("FAIL reset_mid_deliv got %0d want 1", deliv[1] - d1);
      end
      check_counters("reset_mid_after");
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_order();
      test_back_to_back();
      test_reset_mid();
      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
